// File: rtl/fft16_stage_sequencer.sv
// Control sequencer for the radix-2 DIT FFT butterfly datapath.
// Loads in bit-reversed order, runs LOG2N stages, unloads in natural order.
module fft16_stage_sequencer #(
    parameter int N_POINTS = 16,
    parameter int BF_LAT   = 1,
    localparam int LOG2N   = $clog2(N_POINTS),
    localparam int NBF     = N_POINTS / 2,
    localparam int TWW     = LOG2N - 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 load_we,
    output logic [LOG2N-1:0]     load_addr,
    output logic [LOG2N-1:0]     stage,
    output logic                 bf_launch,
    output logic [NBF*TWW-1:0]   tw_idx,
    output logic [NBF*LOG2N-1:0] top_addr,
    output logic [NBF*LOG2N-1:0] bot_addr,
    output logic                 bank_sel,
    output logic                 wb_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG2N-1:0]     out_addr
);

    localparam int WCW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, LAUNCH, WAIT, WB, UNLOAD, DONE
    } state_t;

    state_t           state, state_d;
    logic [LOG2N-1:0] cnt, cnt_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic             bank_q, bank_d;
    logic [WCW-1:0]   wcnt, wcnt_d;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            wcnt    <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            wcnt    <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stage_d = stage_q;
        bank_d  = bank_q;
        wcnt_d  = wcnt;
        // abort outranks start and every handshake
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
            wcnt_d  = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end
                LOAD: if (in_valid) begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_d = LAUNCH;
                        stage_d = '0;
                    end
                end
                LAUNCH: begin
                    wcnt_d  = '0;
                    state_d = (BF_LAT > 0) ? WAIT : WB;
                end
                WAIT: begin
                    wcnt_d = wcnt + 1'b1;
                    if (wcnt == WCW'(BF_LAT - 1)) state_d = WB;
                end
                WB: begin
                    bank_d = ~bank_q;
                    if (stage_q == LAST_STAGE) begin
                        state_d = UNLOAD;
                        cnt_d   = '0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = LAUNCH;
                    end
                end
                UNLOAD: if (out_ready) begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == LAST) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign load_we   = in_valid & in_ready;
    assign load_addr = bitrev(cnt);
    assign bf_launch = (state == LAUNCH);
    assign wb_en     = (state == WB);
    assign out_valid = (state == UNLOAD);
    assign out_addr  = cnt;
    assign done      = (state == DONE);
    assign stage     = stage_q;
    assign bank_sel  = bank_q;

    // lane k pairs (top, top + 2^s); j is its offset inside the 2^s group
    always_comb begin
        int s, j, t;
        s        = int'(stage_q);
        j        = 0;
        t        = 0;
        top_addr = '0;
        bot_addr = '0;
        tw_idx   = '0;
        for (int k = 0; k < NBF; k++) begin
            j = k & ((1 << s) - 1);
            t = ((k >> s) << (s + 1)) | j;
            top_addr[k*LOG2N +: LOG2N] = LOG2N'(t);
            bot_addr[k*LOG2N +: LOG2N] = LOG2N'(t + (1 << s));
            tw_idx[k*TWW +: TWW]       = TWW'(j << (TWW - s));
        end
    end

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Directed bench for fft16_stage_sequencer at N=16, BF_LAT=1.
// Three transforms: plain with backpressure, stalled+aborted, full rerun.
module tb_fft16_stage_sequencer;

    logic        tb_clk = 1'b0;
    logic        n_reset;
    logic        start, abort, in_valid, out_ready;
    logic        busy, done, in_ready, load_we;
    logic        bf_launch, bank_sel, wb_en, out_valid;
    logic [3:0]  load_addr, stage, out_addr;
    logic [23:0] tw_idx;
    logic [31:0] top_addr, bot_addr;

    int checks = 0;
    int errors = 0;

    int br[16]   = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int lane[4]  = '{0, 3, 6, 5};
    int etop[4]  = '{0, 5, 10, 5};
    int ebot[4]  = '{1, 7, 14, 13};
    int etw[4]   = '{0, 4, 4, 5};
    logic bp[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    fft16_stage_sequencer #(.N_POINTS(16), .BF_LAT(1)) dut (
        .clk(tb_clk), .n_reset(n_reset),
        .start(start), .abort(abort),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .load_we(load_we), .load_addr(load_addr),
        .stage(stage), .bf_launch(bf_launch),
        .tw_idx(tw_idx), .top_addr(top_addr),
        .bot_addr(bot_addr), .bank_sel(bank_sel),
        .wb_en(wb_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("in_ready_load", 32'(in_ready), 1);
        check("busy_load", 32'(busy), 1);
    endtask

    task automatic do_load(input int stall_at);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                repeat (5) begin
                    in_valid = 1'b0;
                    #1;
                    check("stall_we", 32'(load_we), 0);
                    check("stall_addr", 32'(load_addr), 14);
                    cyc();
                end
            end
            in_valid = 1'b1;
            #1;
            check("load_we", 32'(load_we), 1);
            check("load_addr", 32'(load_addr), 32'(br[i]));
            cyc();
        end
        in_valid = 1'b0;
        check("launch_after_load", 32'(bf_launch), 1);
        check("in_ready_off", 32'(in_ready), 0);
    endtask

    task automatic do_compute(input int abort_stage);
        for (int s = 0; s < 4; s++) begin
            int l;
            l = lane[s];
            check("launch", 32'(bf_launch), 1);
            check("stage", 32'(stage), 32'(s));
            check("bank", 32'(bank_sel), 32'(s % 2));
            check("top", 32'(top_addr[l*4 +: 4]), 32'(etop[s]));
            check("bot", 32'(bot_addr[l*4 +: 4]), 32'(ebot[s]));
            check("tw", 32'(tw_idx[l*3 +: 3]), 32'(etw[s]));
            cyc();
            check("wait_launch", 32'(bf_launch), 0);
            check("wait_wb", 32'(wb_en), 0);
            check("wait_top", 32'(top_addr[l*4 +: 4]), 32'(etop[s]));
            if (s == abort_stage) begin
                abort = 1'b1;
                start = 1'b1;
                cyc();
                abort = 1'b0;
                start = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_wb", 32'(wb_en), 0);
                check("abort_done", 32'(done), 0);
                cyc();
                check("abort_idle_busy", 32'(busy), 0);
                check("abort_idle_done", 32'(done), 0);
                return;
            end
            cyc();
            check("wb_en", 32'(wb_en), 1);
            check("wb_stage", 32'(stage), 32'(s));
            check("wb_tw", 32'(tw_idx[l*3 +: 3]), 32'(etw[s]));
            cyc();
        end
        check("unload_valid", 32'(out_valid), 1);
        check("unload_bank", 32'(bank_sel), 0);
        check("unload_wb", 32'(wb_en), 0);
    endtask

    task automatic do_unload(input bit use_bp, input bit poke_start);
        int hs, p;
        hs = 0;
        p  = 0;
        while (hs < 16 && p < 100) begin
            out_ready = use_bp ? bp[p % 4] : 1'b1;
            start     = poke_start && (p < 3);
            #1;
            check("out_valid", 32'(out_valid), 1);
            check("out_addr", 32'(out_addr), 32'(hs));
            check("early_done", 32'(done), 0);
            if (out_ready) hs++;
            p++;
            cyc();
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check("unload_count", 32'(hs), 16);
        check("done_pulse", 32'(done), 1);
        check("done_out_valid", 32'(out_valid), 0);
        cyc();
        check("done_once", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_reset   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) cyc();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_launch", 32'(bf_launch), 0);
        check("rst_wb", 32'(wb_en), 0);
        check("rst_bank", 32'(bank_sel), 0);
        check("rst_stage", 32'(stage), 0);
        check("rst_load_addr", 32'(load_addr), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        n_reset = 1'b1;
        cyc();
        check("idle_in_ready", 32'(in_ready), 0);

        do_start();
        do_load(-1);
        do_compute(-1);
        do_unload(1'b1, 1'b0);

        do_start();
        do_load(7);
        do_compute(2);

        do_start();
        do_load(-1);
        do_compute(-1);
        do_unload(1'b0, 1'b1);
        cyc();
        check("start_ignored", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
